// File: rtl/case_decode_pipe.sv
// Two-stage decode pipeline: stage 1 classifies the opcode, stage 2 forms the
// register-select match and presents the delayed control fields downstream.
module case_decode_pipe #(
  parameter logic [2:0] ALU_DO_REGISTER = 3'h1,
  parameter logic [5:0] DSP_REGISTER_V  = 6'h03,
  parameter int         CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_ir,
  input  logic [2:0]       in_alu_ctl,
  input  logic [5:0]       in_reg_addr,
  input  logic [5:0]       in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_ir_2s,
  output logic [2:0]       out_alu_ctl_2s,
  output logic [5:0]       out_reg_addr_2s,
  output logic [5:0]       out_f_2s,
  output logic [2:0]       out_class,
  output logic             out_p00,
  output logic [CNT_W-1:0] match_cnt
);

  logic       s1_valid;
  logic       s2_valid;
  logic       s1_en;
  logic       s2_en;
  logic [7:0] s1_ir;
  logic [2:0] s1_alu_ctl;
  logic [5:0] s1_reg_addr;
  logic [5:0] s1_f;
  logic [2:0] s1_class;
  logic [2:0] in_class;

  // A stage advances when it is empty or the stage after it is draining.
  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  always_comb begin
    in_class = 3'd7;
    casez (in_ir)
      8'b0000_0000: in_class = 3'd0;
      8'b1???_????: in_class = 3'd1;
      8'b01??_??1?: in_class = 3'd2;
      8'b01??_????: in_class = 3'd3;
      8'b001?_????: in_class = 3'd4;
      default:      in_class = 3'd7;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_valid    <= 1'b0;
      s1_ir       <= '0;
      s1_alu_ctl  <= '0;
      s1_reg_addr <= '0;
      s1_f        <= '0;
      s1_class    <= '0;
    end else begin
      if (flush)
        s1_valid <= 1'b0;
      else if (s1_en)
        s1_valid <= in_valid && in_ready;
      if (s1_en) begin
        s1_ir       <= in_ir;
        s1_alu_ctl  <= in_alu_ctl;
        s1_reg_addr <= in_reg_addr;
        s1_f        <= in_f;
        s1_class    <= in_class;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s2_valid        <= 1'b0;
      out_ir_2s       <= '0;
      out_alu_ctl_2s  <= '0;
      out_reg_addr_2s <= '0;
      out_f_2s        <= '0;
      out_class       <= '0;
      out_p00         <= 1'b0;
    end else begin
      if (flush)
        s2_valid <= 1'b0;
      else if (s2_en)
        s2_valid <= s1_valid;
      if (s2_en) begin
        out_ir_2s       <= s1_ir;
        out_alu_ctl_2s  <= s1_alu_ctl;
        out_reg_addr_2s <= s1_reg_addr;
        out_f_2s        <= s1_f;
        out_class       <= s1_class;
        out_p00         <= (s1_alu_ctl == ALU_DO_REGISTER) &&
                           (s1_reg_addr == DSP_REGISTER_V);
      end
    end
  end

  // Counts delivered matches; flush does not touch it, so a transfer in the
  // flush cycle still counts.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)
      match_cnt <= '0;
    else if (out_valid && out_ready && out_p00 && (match_cnt != {CNT_W{1'b1}}))
      match_cnt <= match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_case_decode_pipe.sv
// Self-checking bench for case_decode_pipe: directed scenarios then random
// traffic, compared against a transaction-level queue model.
module tb_case_decode_pipe;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_ir;
  logic [2:0] in_alu_ctl;
  logic [5:0] in_reg_addr;
  logic [5:0] in_f;
  logic       out_ready;

  logic       in_ready, out_valid, out_p00;
  logic [7:0] out_ir_2s;
  logic [2:0] out_alu_ctl_2s, out_class;
  logic [5:0] out_reg_addr_2s, out_f_2s;
  logic [7:0] match_cnt;

  logic       in_ready2, out_valid2, out_p002;
  logic [7:0] out_ir_2s2;
  logic [2:0] out_alu_ctl_2s2, out_class2;
  logic [5:0] out_reg_addr_2s2, out_f_2s2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ir;
    logic [2:0] alu;
    logic [5:0] ra;
    logic [5:0] f;
    logic [2:0] cls;
    logic       p00;
    int         age;
  } entry_t;

  entry_t q[$];
  int     cnt8 = 0;
  int     cnt2 = 0;

  always #5 clk = ~clk;

  case_decode_pipe u_dut (
    .clk(clk), .reset_l(reset_l), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_ir(in_ir), .in_alu_ctl(in_alu_ctl),
    .in_reg_addr(in_reg_addr), .in_f(in_f), .out_valid(out_valid),
    .out_ready(out_ready), .out_ir_2s(out_ir_2s), .out_alu_ctl_2s(out_alu_ctl_2s),
    .out_reg_addr_2s(out_reg_addr_2s), .out_f_2s(out_f_2s), .out_class(out_class),
    .out_p00(out_p00), .match_cnt(match_cnt)
  );

  case_decode_pipe #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset_l(reset_l), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready2), .in_ir(in_ir), .in_alu_ctl(in_alu_ctl),
    .in_reg_addr(in_reg_addr), .in_f(in_f), .out_valid(out_valid2),
    .out_ready(out_ready), .out_ir_2s(out_ir_2s2), .out_alu_ctl_2s(out_alu_ctl_2s2),
    .out_reg_addr_2s(out_reg_addr_2s2), .out_f_2s(out_f_2s2), .out_class(out_class2),
    .out_p00(out_p002), .match_cnt(match_cnt2)
  );

  // Opcode class from value ranges rather than wildcard patterns.
  function automatic logic [2:0] ref_class(input logic [7:0] ir);
    if (ir == 8'd0)       return 3'd0;
    else if (ir >= 8'h80) return 3'd1;
    else if (ir >= 8'h40) return ((ir / 2) % 2 == 1) ? 3'd2 : 3'd3;
    else if (ir >= 8'h20) return 3'd4;
    else                  return 3'd7;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input logic exp_rdy, input logic exp_ov);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("match_cnt", 32'(match_cnt), 32'(cnt8));
    chk("in_ready2", 32'(in_ready2), 32'(exp_rdy));
    chk("out_valid2", 32'(out_valid2), 32'(exp_ov));
    chk("match_cnt2", 32'(match_cnt2), 32'(cnt2));
    if (exp_ov) begin
      chk("ir", 32'(out_ir_2s), 32'(q[0].ir));
      chk("alu_ctl", 32'(out_alu_ctl_2s), 32'(q[0].alu));
      chk("reg_addr", 32'(out_reg_addr_2s), 32'(q[0].ra));
      chk("f", 32'(out_f_2s), 32'(q[0].f));
      chk("class", 32'(out_class), 32'(q[0].cls));
      chk("p00", 32'(out_p00), 32'(q[0].p00));
      chk("p00_2", 32'(out_p002), 32'(q[0].p00));
      chk("class2", 32'(out_class2), 32'(q[0].cls));
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check at mid-cycle,
  // then advance the model across the next edge.
  task automatic apply_stimulus(input logic v, input logic [7:0] ir, input logic [2:0] alu,
                                input logic [5:0] ra, input logic [5:0] f,
                                input logic ordy, input logic fl, output logic acc);
    logic   exp_rdy, exp_ov, out_x;
    entry_t e;
    in_valid = v; in_ir = ir; in_alu_ctl = alu; in_reg_addr = ra; in_f = f;
    out_ready = ordy; flush = fl;
    #4;
    exp_ov  = (q.size() > 0) && (q[0].age >= 1);
    exp_rdy = !((q.size() == 2) && !ordy);
    check_output(exp_rdy, exp_ov);
    acc   = v && exp_rdy && !fl;
    out_x = exp_ov && ordy;
    @(posedge clk); #1;
    foreach (q[i]) q[i].age++;
    if (out_x) begin
      if (q[0].p00) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
      void'(q.pop_front());
    end
    if (fl) q.delete();
    if (acc) begin
      e.ir = ir; e.alu = alu; e.ra = ra; e.f = f;
      e.cls = ref_class(ir); e.p00 = (alu == 3'h1) && (ra == 6'h03); e.age = 0;
      q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_ir"}, 32'(out_ir_2s), 32'd0);
    chk({tag, "_alu"}, 32'(out_alu_ctl_2s), 32'd0);
    chk({tag, "_ra"}, 32'(out_reg_addr_2s), 32'd0);
    chk({tag, "_f"}, 32'(out_f_2s), 32'd0);
    chk({tag, "_class"}, 32'(out_class), 32'd0);
    chk({tag, "_p00"}, 32'(out_p00), 32'd0);
    chk({tag, "_cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, "_cnt2"}, 32'(match_cnt2), 32'd0);
  endtask

  task automatic reset_mid();
    #3 reset_l = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk); #1;
    reset_l = 1'b1;
    q.delete(); cnt8 = 0; cnt2 = 0;
  endtask

  initial begin
    logic       acc;
    logic [7:0] sweep [5];
    int         idx;
    sweep[0] = 8'hA5; sweep[1] = 8'h42; sweep[2] = 8'h41; sweep[3] = 8'h20; sweep[4] = 8'h1F;

    reset_l = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_alu_ctl = '0;
    in_reg_addr = '0; in_f = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    reset_l = 1'b1;

    $display("[TB] single matching word");
    apply_stimulus(1, 8'h00, 3'h1, 6'h03, 6'h00, 1, 0, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);

    $display("[TB] class priority sweep");
    for (int i = 0; i < 5; i++) apply_stimulus(1, sweep[i], 3'h0, 6'h00, 6'(i), 1, 0, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);

    $display("[TB] near-miss matches");
    apply_stimulus(1, 8'h11, 3'h1, 6'h04, 6'h3F, 1, 0, acc);
    apply_stimulus(1, 8'h22, 3'h2, 6'h03, 6'h15, 1, 0, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);

    $display("[TB] backpressure stream");
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      apply_stimulus(1, 8'h40 + 8'(idx), 3'h1, 6'h03, 6'(idx), !(c >= 1 && c <= 3), 0, acc);
      if (acc) idx++;
    end
    chk("stream_all_accepted", 32'(idx), 32'd4);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);

    $display("[TB] flush with both stages full");
    apply_stimulus(1, 8'h81, 3'h1, 6'h03, 6'h01, 0, 0, acc);
    apply_stimulus(1, 8'h82, 3'h1, 6'h03, 6'h02, 0, 0, acc);
    apply_stimulus(1, 8'h83, 3'h1, 6'h03, 6'h03, 0, 1, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);

    $display("[TB] saturation of narrow counter and async reset");
    reset_mid();
    for (int i = 0; i < 5; i++) apply_stimulus(1, 8'h30, 3'h1, 6'h03, 6'h00, 1, 0, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 8'h31, 3'h1, 6'h03, 6'h00, 1, 0, acc);
    reset_mid();

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      logic       v, ordy, fl, m;
      logic [2:0] alu;
      logic [5:0] ra;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      m    = ($urandom_range(0, 1) == 1);
      alu  = m ? 3'h1 : 3'($urandom);
      ra   = m ? 6'h03 : 6'($urandom);
      apply_stimulus(v, 8'($urandom), alu, ra, 6'($urandom), ordy, fl, acc);
      if (c == 700) reset_mid();
    end
    for (int i = 0; i < 4; i++) apply_stimulus(0, 8'h00, 3'h0, 6'h00, 6'h00, 1, 0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
